// File: rtl/fpu_add_sched.sv
// fpu_add_sched: round-robin scheduler sharing one combinational fpu_add between
// NUM_REQ requesters. One operation is in flight at a time. The adder operands are
// registered, and the sum is captured one cycle after the grant. The result goes back
// with the owning requester ID on a single valid/ready response channel.
// Optional build macro: FPU_ADD_SCHED_STATS_EN adds saturating op_count / stall_count.
module fpu_add_sched #(
    parameter int unsigned double  = 0,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    localparam int unsigned Size   = (double != 0) ? 64 : 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*Size-1:0] req_a,
    input  logic [NUM_REQ*Size-1:0] req_b,
    output logic [Size-1:0]         add_a,
    output logic [Size-1:0]         add_b,
    input  logic [Size-1:0]         add_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [Size-1:0]         rsp_result
`ifdef FPU_ADD_SCHED_STATS_EN
    ,
    output logic [31:0]             op_count,
    output logic [31:0]             stall_count
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] id_q;

    logic            grant_en;
    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] ptr_nxt;
    logic            grant;
    logic [Size-1:0] sel_a;
    logic [Size-1:0] sel_b;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        // Descending scan so the last hit is the lowest index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx  = hi_found ? hi_idx : lo_idx;
        ptr_nxt  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        // Grants only when the response slot is free or being freed this cycle.
        grant_en = !rst && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
        grant    = grant_en && lo_found;
    end

    // One-hot grant vector and operand mux for the selected requester.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (gnt_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                sel_a        = req_a[i*Size +: Size];
                sel_b        = req_b[i*Size +: Size];
            end
        end
    end

    // Control FSM with registered adder operands and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            id_q       <= '0;
            add_a      <= '0;
            add_b      <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        add_a   <= sel_a;
                        add_b   <= sel_b;
                        id_q    <= gnt_idx;
                        ptr_q   <= ptr_nxt;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= add_result;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (grant) begin
                            add_a   <= sel_a;
                            add_b   <= sel_b;
                            id_q    <= gnt_idx;
                            ptr_q   <= ptr_nxt;
                            state_q <= StExec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FPU_ADD_SCHED_STATS_EN
    // Saturating counts of completed responses and back-pressured cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count    <= '0;
            stall_count <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (op_count != 32'hFFFF_FFFF)) begin
                op_count <= op_count + 32'd1;
            end
            if (rsp_valid && !rsp_ready && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_add_sched.sv
// Testbench for fpu_add_sched: directed steps plus random traffic, all checked
// against a transaction-level model (grant timestamps, pending requesters, RR pointer).
module tb_fpu_add_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
`ifdef FPU_ADD_SCHED_STATS_EN
    logic [31:0]    op_count;
    logic [31:0]    stall_count;
`endif

    fpu_add_sched #(
        .double  (0),
        .NUM_REQ (N),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef FPU_ADD_SCHED_STATS_EN
        ,
        .op_count   (op_count),
        .stall_count(stall_count)
`endif
    );

    // Stand-in adder: plain integer sum.
    assign add_result = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester side
    logic [N-1:0] pend;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    // Reference model
    int           cyc = 0;
    int           ptr = 0;
    bit           outst = 0;
    int           gcyc = 0;
    int           exp_id = 0;
    logic [W-1:0] exp_a = '0;
    logic [W-1:0] exp_b = '0;
    logic [W-1:0] exp_res = '0;
    int           last_g = -1;
    int           op_m = 0;
    int           stall_m = 0;
    bit           rel = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    endtask

    task automatic step(input logic [N-1:0] mask, input logic rr);
        bit   exp_v;
        bit   allowed;
        int   g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (rel) begin
            rst = 1'b0;
            rel = 0;
        end
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !pend[i]) begin
                pend[i] = 1'b1;
                opa[i]  = $urandom;
                opb[i]  = $urandom;
            end
        end
        drive();
        rsp_ready = rr;
        #1;
        exp_v = outst && (cyc >= gcyc + 2);
        chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
        if (exp_v) begin
            chk("rsp_id", {62'd0, rsp_id}, 64'(exp_id));
            chk("rsp_result", {32'd0, rsp_result}, {32'd0, exp_res});
        end
        if (outst && cyc > gcyc) begin
            chk("add_a", {32'd0, add_a}, {32'd0, exp_a});
            chk("add_b", {32'd0, add_b}, {32'd0, exp_b});
        end
`ifdef FPU_ADD_SCHED_STATS_EN
        chk("op_count", {32'd0, op_count}, 64'(op_m));
        chk("stall_count", {32'd0, stall_count}, 64'(stall_m));
`endif
        allowed = !outst || (exp_v && rr);
        g = -1;
        if (allowed) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        last_g = g;
        if (exp_v && rr) begin
            op_m++;
            outst = 0;
        end
        if (exp_v && !rr) stall_m++;
        if (g >= 0) begin
            outst   = 1;
            gcyc    = cyc;
            exp_id  = g;
            exp_a   = opa[g];
            exp_b   = opb[g];
            exp_res = opa[g] + opb[g];
            ptr     = (g + 1) % N;
            pend[g] = 1'b0;
        end
    endtask

    task automatic run_until_grant(input logic [N-1:0] mask, input logic rr, output int g);
        int n = 0;
        g = -1;
        while (g < 0 && n < 20) begin
            step(mask, rr);
            g = last_g;
            n++;
        end
        checks++;
        assert (g >= 0) else begin
            errors++;
            $error("FAIL grant_timeout: observed no grant in %0d cycles expected a grant", n);
        end
    endtask

    // Asserts reset at a negedge; release happens at the next step.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive();
        #1;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_add_a", {32'd0, add_a}, 64'd0);
        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        outst   = 0;
        ptr     = 0;
        op_m    = 0;
        stall_m = 0;
        rel     = 1;
    endtask

    int g;
    int gc_prev;
    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        pend      = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        pend[2] = 1'b1;
        drive();
        #1;
        chk("reset_add_a", {32'd0, add_a}, 64'd0);
        chk("reset_add_b", {32'd0, add_b}, 64'd0);
        chk("reset_rsp_result", {32'd0, rsp_result}, 64'd0);
        chk("reset_rsp_id", {62'd0, rsp_id}, 64'd0);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_req_ready", {60'd0, req_ready}, 64'd0);
        pend = '0;
        rel  = 1;

        // Single request with the float-pattern operands.
        pend[0] = 1'b1;
        opa[0]  = 32'h3F80_0000;
        opb[0]  = 32'h4000_0000;
        run_until_grant('0, 1'b1, g);
        chk("single_grant", {60'd0, req_ready}, 64'h1);
        step('0, 1'b1);
        chk("single_n1_valid", {63'd0, rsp_valid}, 64'd0);
        step('0, 1'b1);
        chk("single_n2_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_n2_id", {62'd0, rsp_id}, 64'd0);
        chk("single_n2_result", {32'd0, rsp_result}, 64'h7F80_0000);
        step('0, 1'b1);
        chk("single_n3_valid", {63'd0, rsp_valid}, 64'd0);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            run_until_grant(4'b1111, 1'b1, g);
            chk("rr_order", 64'(g), 64'(seq[j]));
            chk("rr_order_dut", {60'd0, req_ready}, 64'(1 << seq[j]));
            if (j > 0) chk("rr_spacing", 64'(cyc - gc_prev), 64'd2);
            gc_prev = cyc;
        end

        // Back-pressure: five stalled cycles, grant when rsp_ready rises.
        do_reset();
        pend = '0;
        run_until_grant(4'b0001, 1'b1, g);
        step(4'b0110, 1'b1);
        for (int j = 0; j < 5; j++) begin
            step(4'b0110, 1'b0);
            chk("bp_no_grant", {60'd0, req_ready}, 64'd0);
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_id", {62'd0, rsp_id}, 64'd0);
        end
        step(4'b0110, 1'b1);
        chk("bp_release_grant", {60'd0, req_ready}, 64'h2);

        // Pointer wrap and skipping of idle requesters.
        pend = '0;
        do_reset();
        run_until_grant(4'b0100, 1'b1, g);
        chk("wrap_setup", 64'(g), 64'd2);
        step('0, 1'b1);
        step('0, 1'b1);
        step('0, 1'b1);
        run_until_grant(4'b1001, 1'b1, g);
        chk("wrap_g3", 64'(g), 64'd3);
        run_until_grant('0, 1'b1, g);
        chk("wrap_g0", 64'(g), 64'd0);
        run_until_grant(4'b0010, 1'b1, g);
        chk("wrap_g1", 64'(g), 64'd1);
        step('0, 1'b1);
        step('0, 1'b1);
        step('0, 1'b1);

        // Reset while an operation is executing.
        run_until_grant(4'b1100, 1'b1, g);
        pend = 4'b1111;
        do_reset();
        run_until_grant('0, 1'b1, g);
        chk("post_reset_grant", {60'd0, req_ready}, 64'h1);

`ifdef FPU_ADD_SCHED_STATS_EN
        // Three operations with four stall cycles.
        pend = '0;
        do_reset();
        run_until_grant(4'b0001, 1'b1, g);
        step('0, 1'b1);
        step('0, 1'b1);
        run_until_grant(4'b0010, 1'b1, g);
        step('0, 1'b1);
        for (int j = 0; j < 4; j++) step('0, 1'b0);
        step('0, 1'b1);
        run_until_grant(4'b0100, 1'b1, g);
        step('0, 1'b1);
        step('0, 1'b1);
        step('0, 1'b1);
        chk("stats_ops", {32'd0, op_count}, 64'd3);
        chk("stats_stalls", {32'd0, stall_count}, 64'd4);
`endif

        // Random traffic.
        for (int j = 0; j < 1500; j++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_add_sched.md
Name: fpu_add_sched

Overview:
- Round-robin scheduler that shares one combinational fpu_add instance between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the selected pair into registered operand ports of the shared adder.
- Captures the adder result one cycle later and returns it with the requester ID over a single valid/ready response channel.
- Sits between issuing DSP engines and the FPU adder; one operation in flight at a time.

Parameters:
- double, 0: 0 = single precision (size 32), 1 = double precision (size 64); must match the attached fpu_add.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of rsp_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  bit i: requester i has an operation pending.
- req_ready  out  NUM_REQ  bit i: requester i granted this cycle. One-hot or zero.
- req_a  in  NUM_REQ*size  operand A; requester i in slice [i*size +: size].
- req_b  in  NUM_REQ*size  operand B; same packing as req_a.
- add_a  out  size  registered operand A to the shared fpu_add.
- add_b  out  size  registered operand B to the shared fpu_add.
- add_result  in  size  combinational result from the shared fpu_add.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  size  registered sum.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state = IDLE; rr pointer = 0.
  - add_a, add_b, rsp_result = 0; rsp_id = 0; rsp_valid = 0; req_ready = 0.
- States:
  - IDLE: if any req_valid, grant in this state, latch operands, go to EXEC. Otherwise stay in IDLE.
  - EXEC: one cycle for adder settling. At the next edge, register add_result into rsp_result, set rsp_valid = 1, go to RESP.
  - RESP: hold rsp_valid, rsp_id and rsp_result stable until rsp_ready. When rsp_valid && rsp_ready:
    - if any req_valid, grant in the same cycle and go to EXEC (back-to-back);
    - otherwise go to IDLE with rsp_valid = 0.
- Grant (req_ready):
  - Combinational, asserted only in IDLE, or in RESP when rsp_ready = 1.
  - Selects the first req_valid bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - On grant to requester i: add_a/add_b <= req slice i; pointer <= (i+1) mod NUM_REQ; the latched ID <= i.
  - The pointer wraps from NUM_REQ-1 to 0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters may not drop req_valid or change operands before the transfer; the block does not check this.
- Latency and throughput:
  - Grant at cycle N, rsp_valid at N+2.
  - With rsp_ready held high, throughput is one operation per 2 cycles.
- Back-pressure: while rsp_valid && !rsp_ready, no grants, and add_a/add_b stay unchanged.
- Mid-operation reset: all state is discarded immediately and the in-flight operation is lost without a response.
- Simultaneous requests: exactly one grant per cycle; round-robin guarantees a requester waits at most NUM_REQ-1 operations.
- rsp_result is a bit-exact copy of add_result; no arithmetic is done in this block.

Optional Feature:
- Macro FPU_ADD_SCHED_STATS_EN.
- Defined:
  - Adds output op_count (32 bits): increments on each response handshake, saturates at 0xFFFFFFFF.
  - Adds output stall_count (32 bits): increments each cycle rsp_valid && !rsp_ready, saturates.
  - Both reset to 0.
- Not defined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Bench adder model returns add_a + add_b (integer).
- Single request: req_valid = 0001, req_a[0] = 0x3F800000, req_b[0] = 0x40000000, rsp_ready = 1. Expect req_ready = 0001 at cycle N; rsp_valid, rsp_id = 0, rsp_result = 0x7F800000 at N+2; rsp_valid low at N+3.
- All four request continuously, rsp_ready = 1. Expect grants in order 0,1,2,3,0, spaced 2 cycles apart; rsp_id in the same order.
- Back-pressure: hold rsp_ready = 0 for 5 cycles after the response. Expect rsp_result and rsp_id stable, req_ready = 0 throughout; grant in the cycle rsp_ready rises.
- Pointer wrap: pointer at 3, req_valid = 1001. Expect grant 3, then 0. Then req_valid = 0010: expect grant 1 (skips idle requesters).
- Reset in EXEC: assert rst. Expect rsp_valid = 0, add_a = 0, req_ready = 0 immediately, no response after release, and the first grant goes to requester 0.
- With FPU_ADD_SCHED_STATS_EN: 3 operations plus 4 stall cycles. Expect op_count = 3, stall_count = 4.
